fact_ctrl: RTL
==============

# fact_ctrl

Control unit for the factorial datapath. It sequences the loadable down-counter (`ld_count`/`EN` interface), the product register and its input mux so that the product register ends holding n!. It handles a go/done handshake with the GPIO-facing wrapper, and it flags inputs too large for the product width.

## Interface
- `N_W`, default 4: width of the operand `n`.
- `MAX_N`, default 12: largest n whose factorial fits the 32-bit product; any larger n raises `err`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `go`  in  1: start request, level-sensitive; sampled only in IDLE, DONE and ERR.
- `n`  in  `N_W`: operand; sampled on the same edge that accepts `go`.
- `gt_one`  in  1: datapath comparator output, 1 when counter Q > 1.
- `ld_count`  out  1: counter load strobe (Q <= n).
- `cnt_en`  out  1: counter decrement enable (Q <= Q-1).
- `ld_reg`  out  1: product register load enable.
- `sel_init`  out  1: product mux select. 1 selects constant 1; 0 selects product*Q.
- `busy`  out  1: 1 in LOAD, CHECK and MULT.
- `done`  out  1: result valid; 1 only in DONE.
- `err`  out  1: operand out of range; 1 only in ERR.

## Operation
- The block is a Moore FSM and all outputs decode from the state register only.
- States are IDLE, LOAD, CHECK, MULT, DONE and ERR.
- IDLE: all outputs are 0.
  - `go`=1 and `n` > `MAX_N`: go to ERR.
  - `go`=1 and `n` ≤ `MAX_N`: go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `ld_count`=1, `ld_reg`=1, `sel_init`=1, `busy`=1. The counter takes n and the product takes 1. Always goes to CHECK.
- CHECK: `busy`=1; all strobes are 0. `gt_one`=1 goes to MULT; `gt_one`=0 goes to DONE.
- MULT: `ld_reg`=1, `sel_init`=0, `cnt_en`=1, `busy`=1. The product becomes product*Q and Q becomes Q-1 on the same edge. Always goes to CHECK.
- DONE: `done`=1 and the product register is stable. Returns to IDLE when `go`=0; stays in DONE while `go`=1, so a held `go` never retriggers.
- ERR: `err`=1. No datapath strobe is asserted, so the counter and product keep their old values. Returns to IDLE when `go`=0.
- `ld_count` and `cnt_en` are never 1 in the same cycle. `ld_reg`=1 with `sel_init`=1 occurs only in LOAD.
- n=0 and n=1 both give product 1, via LOAD → CHECK → DONE.
- Illegal state encodings go to IDLE on the next edge.

## Timing
- Reset: on an edge with `rst_n`=0, state becomes IDLE. From that point every output is 0.
  - This holds from any state, including mid-MULT.
  - The datapath contents are then don't-care.
- Start: let E0 be the edge on which `go`=1 is accepted in IDLE. The FSM is in LOAD after E0 and in CHECK after E1.
- For n ≥ 2, each MULT/CHECK pair takes 2 cycles. DONE is entered after edge E(2n).
- For n ≤ 1, DONE is entered after E2.
- General rule: `done` rises max(2n, 2) cycles after E0.
- ERR is entered directly after E0, so `err` rises 1 cycle after acceptance.
- `gt_one` must reflect the counter value registered on the preceding edge. The datapath comparator is combinational from Q.
- Return from DONE or ERR: the first edge with `go`=0 moves to IDLE. A new start needs `go`=1 on a later edge, so the minimum gap is 1 IDLE cycle.
- `n` is ignored outside the accepting edge. Changing `n` mid-operation has no effect.

## Structure
- Package `fact_pkg`:
  - 3-bit state encoding constants S_IDLE=0, S_LOAD=1, S_CHECK=2, S_MULT=3, S_DONE=4, S_ERR=5.
  - `MAX_N` default.
  - Product width constant 32.
- The range compare `n > MAX_N` is a single comparator inside this module.
- No sub-module: state register, next-state logic and output decode sit in one module.
- The top-level factorial wrapper instantiates `fact_ctrl` alongside the counter, the multiplier, the product register and the mux.

## Test plan
- Reset mid-MULT: n=5; assert `rst_n`=0 during the third MULT. After the next edge: IDLE with all outputs 0. Releasing reset with `go`=0 keeps IDLE.
- n=5, `go` held high: `done` rises exactly 10 cycles after acceptance and the product equals 120. `done` stays high while `go`=1 and returns to IDLE one edge after `go`=0.
- n=0 and n=1: `done` rises 2 cycles after acceptance with product 1. Exactly one `ld_reg` pulse occurs, with `sel_init`=1, and there is no `cnt_en` pulse.
- n=12: product 479001600, with `done` 24 cycles after acceptance. Then n=13: `err` rises 1 cycle after acceptance with no strobes, and the previous product is still held.
- Strobe-pattern check against a bench model of the counter (any n 0..12):
  - `ld_count`/`cnt_en` are never simultaneous.
  - There are exactly max(n-1, 0) `cnt_en` pulses per run.
  - `busy`, `done` and `err` are mutually exclusive.
- Back-to-back starts: n=3 then n=4, with `go` dropped for one cycle between them. The second run is accepted on the first IDLE edge and yields 24.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial control unit.
package fact_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned MAX_N_DEFAULT = 12;
    localparam int unsigned PROD_W        = 32;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MULT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef struct packed {
        logic ld_count;
        logic cnt_en;
        logic ld_reg;
        logic sel_init;
        logic busy;
        logic done;
        logic err;
    } ctrl_out_t;

    // Moore output decode; unknown encodings decode to all-zero like IDLE.
    function automatic ctrl_out_t decode(input state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_LOAD: begin
                o.ld_count = 1'b1;
                o.ld_reg   = 1'b1;
                o.sel_init = 1'b1;
                o.busy     = 1'b1;
            end
            S_CHECK: o.busy = 1'b1;
            S_MULT: begin
                o.ld_reg = 1'b1;
                o.cnt_en = 1'b1;
                o.busy   = 1'b1;
            end
            S_DONE:  o.done = 1'b1;
            S_ERR:   o.err  = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fact_if.sv
// Handshake and datapath-control bundle between the wrapper and fact_ctrl.
interface fact_if #(
    parameter int unsigned N_W = 4
);
    logic           go;
    logic [N_W-1:0] n;
    logic           gt_one;
    logic           ld_count;
    logic           cnt_en;
    logic           ld_reg;
    logic           sel_init;
    logic           busy;
    logic           done;
    logic           err;

    modport master (
        output go, n, gt_one,
        input  ld_count, cnt_en, ld_reg, sel_init, busy, done, err
    );

    modport slave (
        input  go, n, gt_one,
        output ld_count, cnt_en, ld_reg, sel_init, busy, done, err
    );
endinterface

// File: rtl/fact_ctrl.sv
// Moore FSM sequencing the factorial counter, product register and mux.
module fact_ctrl
    import fact_pkg::*;
#(
    parameter int unsigned N_W   = 4,
    parameter int unsigned MAX_N = MAX_N_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    fact_if.slave bus
);

    state_t         state;
    state_t         state_next;
    ctrl_out_t      out_q;
    ctrl_out_t      out_next;
    logic [N_W-1:0] n_val;
    logic           too_big;

    assign n_val   = bus.n;
    assign too_big = 32'(n_val) > 32'(MAX_N);

    // State and output registers; outputs track the decode of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            out_q <= '0;
        end else begin
            state <= state_next;
            out_q <= out_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.go) state_next = too_big ? S_ERR : S_LOAD;
            end
            S_LOAD:  state_next = S_CHECK;
            S_CHECK: state_next = bus.gt_one ? S_MULT : S_DONE;
            S_MULT:  state_next = S_CHECK;
            S_DONE:  if (!bus.go) state_next = S_IDLE;
            S_ERR:   if (!bus.go) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        out_next = decode(state_next);
    end

    assign bus.ld_count = out_q.ld_count;
    assign bus.cnt_en   = out_q.cnt_en;
    assign bus.ld_reg   = out_q.ld_reg;
    assign bus.sel_init = out_q.sel_init;
    assign bus.busy     = out_q.busy;
    assign bus.done     = out_q.done;
    assign bus.err      = out_q.err;

endmodule
